pe_seq_ctrl: RTL and testbench

- Sequencer that owns one pe_unit for the duration of a job.
- Clears the PE's eight accumulators, then streams K passes of eight operand pairs into it (one pair per accumulator slot, slot index cycling 0..7) from an upstream valid/ready source, stalling the PE via keep when the source starves.
- Then drains all eight slots through the PE rounder and re-emits the rounded results as an indexed stream with a done pulse.
- Sits between the operand buffer/scheduler and a single PE.

---
 rtl/pe_ctrl_pkg.sv | 21 ++
 rtl/pe_seq_ctrl_if.sv | 20 ++
 rtl/pe_rd_tracker.sv | 62 ++++++
 rtl/pe_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared types and sizes
// for the PE sequencer slice.
package pe_ctrl_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ACC,
    S_SETTLE,
    S_DRAIN,
    S_FLUSH
  } state_e;

  function automatic int pe_dw(int ib, int fb);
    return ib + fb;
  endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if: operand-pair valid/ready
// stream into the PE sequencer.
interface pe_seq_ctrl_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready
  );
endinterface

// File: rtl/pe_rd_tracker.sv
// pe_rd_tracker: rounder-latency delay line
// producing the indexed result stream.
module pe_rd_tracker
  import pe_ctrl_pkg::*;
#(
  parameter int DW     = 16,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              issue_i,
  input  logic [SLOT_W-1:0] issue_idx_i,
  input  logic [DW-1:0]     pe_data_i,
  input  logic              pe_rv_i,
  output logic              res_valid_o,
  output logic [SLOT_W-1:0] res_idx_o,
  output logic [DW-1:0]     res_data_o,
  output logic              done_o,
  output logic              err_o
);

  logic [RD_LAT-1:0] v_q;
  logic [SLOT_W-1:0] idx_q [RD_LAT];
  logic              err_q;
  logic              last_hit;

  assign res_valid_o = v_q[RD_LAT-1];
  assign res_idx_o   = idx_q[RD_LAT-1];
  assign res_data_o  = pe_data_i;
  assign last_hit    = res_valid_o &&
                       (res_idx_o == SLOT_W'(NUM_SLOTS-1));
  assign done_o      = last_hit;
  assign err_o       = err_q;

  // shift issued slot indices toward the tail
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < RD_LAT; i++)
        idx_q[i] <= '0;
    end else begin
      v_q[0]   <= issue_i;
      idx_q[0] <= issue_idx_i;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i]   <= v_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  // sticky flag: PE slot-7 flag vs our own timing
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (clr_i)
      err_q <= 1'b0;
    else if (pe_rv_i != last_hit)
      err_q <= 1'b1;
  end

endmodule

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: clears one PE, streams K passes
// of operand pairs, drains and re-emits results.
module pe_seq_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int INT_BITS   = 7,
  parameter int FRAC_BITS  = 9,
  parameter int LEN_W      = 8,
  parameter int ACC_SETTLE = 2,
  parameter int RD_LAT     = 3,
  localparam int DW = pe_dw(INT_BITS, FRAC_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] k_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  pe_seq_ctrl_if.slave     op,
  output logic             pe_rst_n,
  output logic [DW-1:0]    pe_data_in_1,
  output logic [DW-1:0]    pe_data_in_2,
  output logic [3:0]       pe_add_number,
  output logic             pe_rounder_en,
  output logic             pe_keep,
  input  logic [DW-1:0]    pe_data_out,
  input  logic             pe_rounder_valid,
  output logic             res_valid,
  output logic [2:0]       res_idx,
  output logic [DW-1:0]    res_data
);

  localparam logic [SLOT_W-1:0] SETTLE_LAST =
    SLOT_W'(ACC_SETTLE - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST =
    SLOT_W'(NUM_SLOTS - 1);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] cnt_q, beat_q, slot_q;
  logic [LEN_W-1:0]  pass_q, k_q;
  logic [DW-1:0]     a_q, b_q;
  logic              start_acc, hs, last_beat;

  assign start_acc = (state_q == S_IDLE) && start;
  assign hs        = (state_q == S_ACC) && op.in_valid;
  assign last_beat = (beat_q == SLOT_LAST) &&
                     (pass_q == k_q - LEN_W'(1));
  assign busy      = (state_q != S_IDLE);
  assign pe_rst_n  = ~(rst | (state_q == S_CLR));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start) state_d = S_CLR;
      S_CLR:
        if (cnt_q == SLOT_W'(1))
          state_d = (k_q == '0) ? S_SETTLE : S_ACC;
      S_ACC:
        if (hs && last_beat) state_d = S_SETTLE;
      S_SETTLE:
        if (cnt_q == SETTLE_LAST) state_d = S_DRAIN;
      S_DRAIN:
        if (cnt_q == SLOT_LAST) state_d = S_FLUSH;
      S_FLUSH:
        if (done) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // phase/beat/pass counters and held operands
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      beat_q <= '0;
      pass_q <= '0;
      k_q    <= '0;
      slot_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      if (state_d != state_q) cnt_q <= '0;
      else                    cnt_q <= cnt_q + 1'b1;
      if (start_acc) k_q <= k_len;
      if (state_q == S_CLR) begin
        beat_q <= '0;
        pass_q <= '0;
        slot_q <= '0;
        a_q    <= '0;
        b_q    <= '0;
      end else if (hs) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == SLOT_LAST)
          pass_q <= pass_q + 1'b1;
        slot_q <= beat_q;
        a_q    <= op.in_a;
        b_q    <= op.in_b;
      end
    end
  end

  // PE-facing and upstream outputs
  always_comb begin
    op.in_ready   = 1'b0;
    pe_keep       = 1'b0;
    pe_rounder_en = 1'b0;
    pe_add_number = {1'b0, slot_q};
    pe_data_in_1  = '0;
    pe_data_in_2  = '0;
    unique case (state_q)
      S_ACC: begin
        op.in_ready = 1'b1;
        if (op.in_valid) begin
          pe_add_number = {1'b0, beat_q};
          pe_data_in_1  = op.in_a;
          pe_data_in_2  = op.in_b;
        end else begin
          pe_keep      = 1'b1;
          pe_data_in_1 = a_q;
          pe_data_in_2 = b_q;
        end
      end
      S_DRAIN: begin
        pe_rounder_en = 1'b1;
        pe_add_number = {1'b0, cnt_q};
      end
      default: ;
    endcase
  end

  pe_rd_tracker #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_trk (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_acc),
    .issue_i     (pe_rounder_en),
    .issue_idx_i (pe_add_number[2:0]),
    .pe_data_i   (pe_data_out),
    .pe_rv_i     (pe_rounder_valid),
    .res_valid_o (res_valid),
    .res_idx_o   (res_idx),
    .res_data_o  (res_data),
    .done_o      (done),
    .err_o       (err)
  );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed bench with a small
// behavioural PE attached to the sequencer.
module tb_pe_seq_ctrl;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    k_len = '0;
  logic          busy, done, err;
  logic          pe_rst_n, pe_rounder_en, pe_keep;
  logic [DW-1:0] pe_data_in_1, pe_data_in_2;
  logic [3:0]    pe_add_number;
  logic [DW-1:0] pe_data_out;
  logic          pe_rounder_valid;
  logic          res_valid;
  logic [2:0]    res_idx;
  logic [DW-1:0] res_data;

  int checks = 0;
  int errors = 0;

  pe_seq_ctrl_if #(.DW(DW)) op_if();

  pe_seq_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .k_len            (k_len),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .op               (op_if.slave),
    .pe_rst_n         (pe_rst_n),
    .pe_data_in_1     (pe_data_in_1),
    .pe_data_in_2     (pe_data_in_2),
    .pe_add_number    (pe_add_number),
    .pe_rounder_en    (pe_rounder_en),
    .pe_keep          (pe_keep),
    .pe_data_out      (pe_data_out),
    .pe_rounder_valid (pe_rounder_valid),
    .res_valid        (res_valid),
    .res_idx          (res_idx),
    .res_data         (res_data)
  );

  always #5 clk = ~clk;

  // behavioural PE: Q7.9 MAC into 8 slots, 3-cycle rounder
  logic signed [39:0] acc [8];
  logic [DW-1:0]      rd0, rd1, rd2;
  logic [2:0]         rv_q;
  logic               early = 1'b0;

  function automatic logic signed [39:0] mul(
    input logic [15:0] a, input logic [15:0] b);
    logic signed [39:0] x, y;
    x = {{24{a[15]}}, a};
    y = {{24{b[15]}}, b};
    return x * y;
  endfunction

  function automatic logic [DW-1:0] rnd(
    input logic signed [39:0] v);
    logic signed [39:0] t;
    t = (v + 40'sd256) >>> 9;
    return t[DW-1:0];
  endfunction

  always @(posedge clk) begin
    if (!pe_rst_n) begin
      for (int i = 0; i < 8; i++) acc[i] <= '0;
      rd0  <= '0;
      rd1  <= '0;
      rd2  <= '0;
      rv_q <= '0;
    end else begin
      if (!pe_keep)
        acc[pe_add_number[2:0]] <= acc[pe_add_number[2:0]] +
          mul(pe_data_in_1, pe_data_in_2);
      rd0  <= pe_rounder_en ? rnd(acc[pe_add_number[2:0]]) : '0;
      rd1  <= rd0;
      rd2  <= rd1;
      rv_q <= {rv_q[1:0],
               pe_rounder_en && (pe_add_number[2:0] == 3'd7)};
    end
  end

  assign pe_data_out      = rd2;
  assign pe_rounder_valid = rv_q[2] | (early & rv_q[1]);

  // per-job observations
  logic [15:0] got [8];
  int  done_cyc, n_res, idx_bad, seq_bad, keep_cnt, keep_bad;
  int  ready_cnt, ren_cnt, beats;
  logic err_c1, busy_c1, err_end, busy_end;

  task automatic run_job(input int k, input int mode,
                         input int stall_at, input int stall_len,
                         input int extra_start);
    int beat, stall_left, nexp;
    beat = 0; stall_left = stall_len; nexp = 0;
    done_cyc = -1; idx_bad = 0; seq_bad = 0;
    keep_cnt = 0; keep_bad = 0; ready_cnt = 0; ren_cnt = 0;
    for (int i = 0; i < 8; i++) got[i] = 16'hdead;
    @(negedge clk);
    start = 1'b1;
    k_len = k[7:0];
    for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = (cyc == extra_start);
      if (beat == stall_at && stall_left > 0) begin
        op_if.in_valid = 1'b0;
        stall_left--;
      end else if (beat < 8 * k) begin
        op_if.in_valid = 1'b1;
        op_if.in_a = (mode == 0) ? 16'h0200 : 16'((beat % 8) << 9);
        op_if.in_b = 16'h0200;
      end else begin
        op_if.in_valid = 1'b0;
      end
      #1;
      if (cyc == 1) begin
        err_c1 = err;
        busy_c1 = busy;
      end
      if (op_if.in_ready) ready_cnt++;
      if (pe_rounder_en) ren_cnt++;
      if (pe_keep) begin
        keep_cnt++;
        if (pe_add_number !== 4'((beat + 7) % 8)) keep_bad++;
      end
      if (op_if.in_ready && op_if.in_valid) begin
        if (pe_add_number !== 4'(beat % 8)) seq_bad++;
        if (pe_data_in_1 !== op_if.in_a) seq_bad++;
        beat++;
      end
      if (res_valid) begin
        if (res_idx !== 3'(nexp)) idx_bad++;
        got[res_idx] = res_data;
        nexp++;
      end
      if (done) done_cyc = cyc;
    end
    beats = beat;
    n_res = nexp;
    op_if.in_valid = 1'b0;
    @(negedge clk);
    #1;
    busy_end = busy;
    err_end = err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, err, op_if.in_ready, res_valid,
         pe_rounder_en, pe_keep} !== 7'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 0", {busy, done, err,
        op_if.in_ready, res_valid, pe_rounder_en, pe_keep});
    end
    checks++;
    if (pe_add_number !== 4'd0 || pe_data_in_1 !== 16'd0 ||
        pe_data_in_2 !== 16'd0) begin
      errors++;
      $display("FAIL rst_pe_bus got %h/%h/%h want 0",
               pe_add_number, pe_data_in_1, pe_data_in_2);
    end
    checks++;
    if (pe_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_pe_rst_n got %b want 0", pe_rst_n);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (pe_rst_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_release got %b%b want 10", pe_rst_n, busy);
    end
  endtask

  task automatic test_k1();
    int bad;
    run_job(1, 0, -1, 0, -1);
    bad = 0;
    for (int s = 0; s < 8; s++) if (got[s] !== 16'h0200) bad++;
    checks++;
    if (done_cyc != 23) begin
      errors++;
      $display("FAIL k1_latency got %0d want 23", done_cyc);
    end
    checks++;
    if (bad != 0 || n_res != 8 || idx_bad != 0) begin
      errors++;
      $display("FAIL k1_results bad %0d n %0d idx_bad %0d want 0 8 0",
               bad, n_res, idx_bad);
    end
    checks++;
    if (err_end !== 1'b0 || busy_end !== 1'b0 || busy_c1 !== 1'b1) begin
      errors++;
      $display("FAIL k1_flags err %b busy_end %b busy_c1 %b want 001",
               err_end, busy_end, busy_c1);
    end
    checks++;
    if (ready_cnt != 8 || ren_cnt != 8 || keep_cnt != 0) begin
      errors++;
      $display("FAIL k1_counts ready %0d ren %0d keep %0d want 8 8 0",
               ready_cnt, ren_cnt, keep_cnt);
    end
  endtask

  task automatic test_k3();
    int bad;
    run_job(3, 1, -1, 0, -1);
    bad = 0;
    for (int s = 0; s < 8; s++) if (got[s] !== 16'(s * 1536)) bad++;
    checks++;
    if (bad != 0 || n_res != 8) begin
      errors++;
      $display("FAIL k3_results bad %0d n %0d want 0 8", bad, n_res);
    end
    checks++;
    if (seq_bad != 0 || beats != 24) begin
      errors++;
      $display("FAIL k3_slot_seq bad %0d beats %0d want 0 24",
               seq_bad, beats);
    end
    checks++;
    if (done_cyc != 39) begin
      errors++;
      $display("FAIL k3_latency got %0d want 39", done_cyc);
    end
  endtask

  task automatic test_stall();
    int bad;
    run_job(2, 1, 4, 5, -1);
    bad = 0;
    for (int s = 0; s < 8; s++) if (got[s] !== 16'(s * 1024)) bad++;
    checks++;
    if (keep_cnt != 5 || keep_bad != 0) begin
      errors++;
      $display("FAIL stall_keep cnt %0d bad %0d want 5 0",
               keep_cnt, keep_bad);
    end
    checks++;
    if (bad != 0 || seq_bad != 0) begin
      errors++;
      $display("FAIL stall_results bad %0d seq %0d want 0 0",
               bad, seq_bad);
    end
    checks++;
    if (done_cyc != 36) begin
      errors++;
      $display("FAIL stall_latency got %0d want 36", done_cyc);
    end
  endtask

  task automatic test_k0();
    int bad;
    run_job(0, 0, -1, 0, 5);
    bad = 0;
    for (int s = 0; s < 8; s++) if (got[s] !== 16'h0000) bad++;
    checks++;
    if (ready_cnt != 0) begin
      errors++;
      $display("FAIL k0_no_ready got %0d want 0", ready_cnt);
    end
    checks++;
    if (bad != 0 || n_res != 8 || idx_bad != 0) begin
      errors++;
      $display("FAIL k0_results bad %0d n %0d idx_bad %0d want 0 8 0",
               bad, n_res, idx_bad);
    end
    checks++;
    if (done_cyc != 15 || busy_end !== 1'b0) begin
      errors++;
      $display("FAIL k0_done cyc %0d busy_end %b want 15 0",
               done_cyc, busy_end);
    end
  endtask

  task automatic test_mid_reset();
    int beat, bad;
    beat = 0;
    @(negedge clk);
    start = 1'b1;
    k_len = 8'd2;
    for (int cyc = 1; cyc <= 60 && beat < 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      op_if.in_valid = 1'b1;
      op_if.in_a = 16'h0600;
      op_if.in_b = 16'h0200;
      #1;
      if (op_if.in_ready && op_if.in_valid) beat++;
    end
    @(negedge clk);
    rst = 1'b1;
    op_if.in_valid = 1'b0;
    #1;
    checks++;
    if (pe_rst_n !== 1'b0 || beat != 12) begin
      errors++;
      $display("FAIL midrst_pe_rst_n got %b beats %0d want 0 12",
               pe_rst_n, beat);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || op_if.in_ready !== 1'b0 || pe_keep !== 1'b0 ||
        pe_add_number !== 4'd0 || pe_data_in_1 !== 16'd0) begin
      errors++;
      $display("FAIL midrst_idle busy %b rdy %b keep %b add %h d %h",
               busy, op_if.in_ready, pe_keep, pe_add_number,
               pe_data_in_1);
    end
    rst = 1'b0;
    run_job(1, 0, -1, 0, -1);
    bad = 0;
    for (int s = 0; s < 8; s++) if (got[s] !== 16'h0200) bad++;
    checks++;
    if (bad != 0 || done_cyc != 23 || err_end !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rerun bad %0d cyc %0d err %b want 0 23 0",
               bad, done_cyc, err_end);
    end
  endtask

  task automatic test_err();
    early = 1'b1;
    run_job(1, 0, -1, 0, -1);
    early = 1'b0;
    checks++;
    if (err_end !== 1'b1) begin
      errors++;
      $display("FAIL err_set got %b want 1", err_end);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b want 1", err);
    end
    run_job(1, 0, -1, 0, -1);
    checks++;
    if (err_c1 !== 1'b0 || err_end !== 1'b0) begin
      errors++;
      $display("FAIL err_clear c1 %b end %b want 0 0", err_c1, err_end);
    end
  endtask

  initial begin
    op_if.in_valid = 1'b0;
    op_if.in_a = '0;
    op_if.in_b = '0;
    test_reset();
    test_k1();
    test_k3();
    test_stall();
    test_k0();
    test_mid_reset();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
